// File: rtl/wbc_arbiter_pkg.sv
// Shared definitions for the wbc control-bus arbiter: master indices,
// FSM state encoding and the default watchdog timeout.
package wbc_arbiter_pkg;

    localparam int WBC_M_PCIC  = 0;
    localparam int WBC_M_TURFC = 1;
    localparam int WBC_M_HKMC  = 2;

    localparam int WBC_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        WBC_ARB_IDLE = 2'd0,
        WBC_ARB_OWN  = 2'd1,
        WBC_ARB_TERM = 2'd2
    } wbc_arb_state_t;

endpackage

// File: rtl/wbc_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from last+1, wrapping at NUM_MASTERS.
module wbc_rr_pick #(
    parameter int NUM_MASTERS = 3,
    parameter int SEL_BITS    = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SEL_BITS-1:0]    last,
    output logic [SEL_BITS-1:0]    winner,
    output logic                   valid
);

    logic [SEL_BITS-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = SEL_BITS'((int'(last) + i) % NUM_MASTERS);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbc_arbiter.sv
// Round-robin arbiter for the control WISHBONE bus with a stalled-slave
// watchdog that terminates the cycle with a synthesized err.
//
//  state | meaning
//  IDLE  | no owner; arbitrate among cyc requests
//  OWN   | grant held while the owner keeps cyc high; watchdog running
//  TERM  | watchdog fired; one-cycle err/kill pulse to the owner
module wbc_arbiter
    import wbc_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = WBC_TIMEOUT_DEFAULT,
    parameter int TO_CNT_BITS    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_MASTERS-1:0] cyc_i,
    input  logic [NUM_MASTERS-1:0] stb_i,
    input  logic                   slv_ack_i,
    input  logic                   slv_err_i,
    input  logic                   slv_rty_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [SEL_BITS-1:0]    sel_o,
    output logic                   busy_o,
    output logic                   to_err_o,
    output logic                   slv_kill_o,
    output logic [7:0]             to_count_o
);

    localparam logic [TO_CNT_BITS-1:0] TO_LIMIT = TO_CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_BITS-1:0]    LAST_RST = SEL_BITS'(NUM_MASTERS - 1);

    wbc_arb_state_t          state, state_nxt;
    logic [NUM_MASTERS-1:0]  gnt_nxt;
    logic [SEL_BITS-1:0]     sel_nxt, last, last_nxt;
    logic                    busy_nxt, term_nxt;
    logic [TO_CNT_BITS-1:0]  to_cnt, to_cnt_nxt;
    logic [7:0]              to_count_nxt;
    logic [SEL_BITS-1:0]     pick_idx;
    logic                    pick_valid;
    logic                    slv_resp;

    assign slv_resp = slv_ack_i | slv_err_i | slv_rty_i;

    wbc_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .SEL_BITS    (SEL_BITS)
    ) u_pick (
        .req    (cyc_i),
        .last   (last),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= WBC_ARB_IDLE;
            gnt_o      <= '0;
            sel_o      <= '0;
            busy_o     <= 1'b0;
            last       <= LAST_RST;
            to_cnt     <= '0;
            to_err_o   <= 1'b0;
            slv_kill_o <= 1'b0;
            to_count_o <= '0;
        end else begin
            state      <= state_nxt;
            gnt_o      <= gnt_nxt;
            sel_o      <= sel_nxt;
            busy_o     <= busy_nxt;
            last       <= last_nxt;
            to_cnt     <= to_cnt_nxt;
            to_err_o   <= term_nxt;
            slv_kill_o <= term_nxt;
            to_count_o <= to_count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt_o;
        sel_nxt      = sel_o;
        busy_nxt     = busy_o;
        last_nxt     = last;
        to_cnt_nxt   = to_cnt;
        to_count_nxt = to_count_o;
        term_nxt     = 1'b0;

        case (state)
            WBC_ARB_IDLE: begin
                to_cnt_nxt = '0;
                if (pick_valid) begin
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    sel_nxt           = pick_idx;
                    busy_nxt          = 1'b1;
                    last_nxt          = pick_idx;
                    state_nxt         = WBC_ARB_OWN;
                end
            end
            WBC_ARB_OWN: begin
                // Owner release takes precedence over any watchdog activity.
                if (!cyc_i[sel_o]) begin
                    gnt_nxt    = '0;
                    busy_nxt   = 1'b0;
                    to_cnt_nxt = '0;
                    state_nxt  = WBC_ARB_IDLE;
                end else if (slv_resp) begin
                    to_cnt_nxt = '0;
                end else if (stb_i[sel_o]) begin
                    if (to_cnt == TO_LIMIT) begin
                        to_cnt_nxt = '0;
                        term_nxt   = 1'b1;
                        state_nxt  = WBC_ARB_TERM;
                        if (to_count_o != 8'hFF) begin
                            to_count_nxt = to_count_o + 8'd1;
                        end
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                    end
                end
            end
            WBC_ARB_TERM: begin
                if (cyc_i[sel_o]) begin
                    state_nxt = WBC_ARB_OWN;
                end else begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = WBC_ARB_IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = WBC_ARB_IDLE;
            end
        endcase
    end

endmodule
